alu_issue_fifo: RTL
===================

# alu_issue_fifo

Operand-issue stage directly upstream of the 64-bit ALU in the execute path. It buffers ALU operations (A, B, ALU_Sel) in a small FIFO with a valid/ready input handshake, and drives the head operation onto the ALU's combinational inputs. It captures the ALU's result, carry-out and zero flag into a registered output with its own valid/ready handshake. This decouples the operation producer from the result consumer while sustaining one operation per cycle.

## Interface
- ANCHO, 64, operand/result width; must match the ALU.
- PROFUNDIDAD, 4, FIFO depth in entries; power of two, ≥2.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  producer offers an operation.
- in_ready  output  1  FIFO can accept; high when count < PROFUNDIDAD.
- in_A, in_B  input  ANCHO  operands.
- in_Sel  input  4  ALU operation select.
- alu_A, alu_B  output  ANCHO  to ALU A/B.
- alu_Sel  output  4  to ALU ALU_Sel.
- alu_Out  input  ANCHO  from ALU ALU_Out.
- alu_coutfin  input  1  from ALU coutfin.
- alu_z  input  1  from ALU z.
- res_valid  output  1  registered result available.
- res_ready  input  1  consumer accepts result.
- res_Out  output  ANCHO  captured result.
- res_coutfin, res_z  output  1  captured flags.
- count  output  $clog2(PROFUNDIDAD+1)  FIFO occupancy (result register excluded).

## Operation
- Push: in_valid && in_ready at an edge writes {in_A, in_B, in_Sel} at the write pointer; the write pointer advances.
- in_ready depends only on count, never on same-cycle pop; when full, a push is refused even if a pop occurs that cycle.
- Head drive: when count>0, alu_A/alu_B/alu_Sel are the head entry (combinational from storage). When empty: alu_A=0, alu_B=0, alu_Sel=4'b1111 (NOP; the ALU outputs 0).
- Load condition: count>0 && (!res_valid || res_ready). On load: res_Out/res_coutfin/res_z <= alu_Out/alu_coutfin/alu_z, res_valid<=1, pop head (read pointer advances).
- Drain: if not loading and res_ready, res_valid<=0; res_* hold their old values.
- Stall: while res_valid && !res_ready, res_* and res_valid hold stable and nothing pops.
- Simultaneous push and pop: count unchanged and both pointers advance.
- Pointers are $clog2(PROFUNDIDAD) bits and wrap naturally; full/empty are decided by count only.
- Undefined Sel codes are accepted and passed through unchanged; the ALU yields 0, z=1, and res reflects that.
- No bypass: an operation always passes through the FIFO.

## Timing
- Reset (rst_n low at an edge): count=0, pointers=0, res_valid=0, res_Out=0, res_coutfin=0, res_z=0. Consequently in_ready=1, alu_Sel=4'b1111, alu_A=alu_B=0.
- Reset mid-operation discards all queued entries and any pending result, with no partial pop.
- Latency: push accepted at edge N, with the FIFO empty and the result register free, gives res_valid high in the cycle after edge N+1 (2 edges).
- Throughput: one operation per cycle sustained while res_ready=1.
- Maximum in flight: PROFUNDIDAD in the FIFO plus 1 in the result register.

## Structure
- Shared package alu_pkg holds:
  - ALU_Sel constants: ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_NOP=4'b1111.
  - A packed typedef alu_op_t {A, B, Sel}, parameterised on ANCHO via a package constant ANCHO_DEF=64.
- One sub-module, alu_op_fifo: storage, pointers, count, push/pop, head output.
- The top level adds the NOP mux and the result register.
- The ALU is not instantiated inside; it is connected at the execute-stage level.

## Test plan
- Single ADD: push A=64'hFFFF_FFFF_FFFF_FFFF, B=1, Sel=0010 with res_ready=1 -> 2 edges later res_valid=1, res_Out=0, res_coutfin=1, res_z=1; res_valid=0 the cycle after.
- Back-to-back: push AND(F0F0…,FF00…), OR(0,0), ADD(5,7) on consecutive cycles -> results F000…, 0 (z=1), 12 (z=0) on consecutive cycles in order; count never exceeds 1.
- Full/backpressure: res_ready=0, push 6 ops -> 5 accepted (1 in result register, count=4), in_ready=0 on the 6th. res_Out stays on op 1 until res_ready rises, then ops 2–5 drain one per cycle.
- Full with simultaneous pop: count=4, res_ready=1, in_valid=1 -> push refused that cycle, count goes to 3, and the push is accepted on the next cycle.
- Reset mid-stream: 3 queued and res_valid=1, then rst_n=0 for one edge -> all outputs at reset values, alu_Sel=1111, and subsequent pushes restart cleanly.
- Invalid Sel 4'b0111 with A=B=3 -> res_Out=0, res_z=1, res_coutfin equals the ALU's adder carry (0).

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: ALU select codes and the queued operation record shared by the issue stage.
package alu_pkg;
  localparam int ANCHO_DEF = 64;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_NOP = 4'b1111;
  typedef struct packed {
    logic [ANCHO_DEF-1:0] a;
    logic [ANCHO_DEF-1:0] b;
    logic [3:0]           sel;
  } alu_op_t;
endpackage

// File: rtl/alu_issue_fifo_if.sv
// alu_issue_fifo_if: operation-in and result-out handshakes of the ALU issue stage.
interface alu_issue_fifo_if #(parameter int ANCHO = alu_pkg::ANCHO_DEF) ();
  logic             in_valid;
  logic             in_ready;
  logic [ANCHO-1:0] in_A;
  logic [ANCHO-1:0] in_B;
  logic [3:0]       in_Sel;
  logic             res_valid;
  logic             res_ready;
  logic [ANCHO-1:0] res_Out;
  logic             res_coutfin;
  logic             res_z;
  modport master (output in_valid, in_A, in_B, in_Sel, res_ready,
                  input  in_ready, res_valid, res_Out, res_coutfin, res_z);
  modport slave  (input  in_valid, in_A, in_B, in_Sel, res_ready,
                  output in_ready, res_valid, res_Out, res_coutfin, res_z);
endinterface

// File: rtl/alu_op_fifo.sv
// alu_op_fifo: operation storage with count-based full/empty and a combinational head.
module alu_op_fifo import alu_pkg::*; #(
  parameter int PROFUNDIDAD = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               push_req,
  input  logic                               pop,
  input  alu_op_t                            wr_op,
  output alu_op_t                            head,
  output logic                               ready,
  output logic                               empty,
  output logic [$clog2(PROFUNDIDAD+1)-1:0]   count
);
  localparam int PW = $clog2(PROFUNDIDAD);
  localparam int CW = $clog2(PROFUNDIDAD+1);
  alu_op_t mem [PROFUNDIDAD];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic push;
  // ready looks only at count, so a full FIFO refuses even when popping this cycle
  assign ready = count < CW'(PROFUNDIDAD);
  assign empty = count == '0;
  assign push  = push_req && ready;
  assign head  = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_op;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/alu_issue_fifo.sv
// alu_issue_fifo: buffers ALU ops, drives the head onto the ALU and registers its result.
module alu_issue_fifo import alu_pkg::*; #(
  parameter int ANCHO       = ANCHO_DEF,
  parameter int PROFUNDIDAD = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  alu_issue_fifo_if.slave                  io,
  output logic [ANCHO-1:0]                 alu_A,
  output logic [ANCHO-1:0]                 alu_B,
  output logic [3:0]                       alu_Sel,
  input  logic [ANCHO-1:0]                 alu_Out,
  input  logic                             alu_coutfin,
  input  logic                             alu_z,
  output logic [$clog2(PROFUNDIDAD+1)-1:0] count
);
  alu_op_t wr_op, head;
  logic empty, load;
  assign wr_op = '{a: io.in_A, b: io.in_B, sel: io.in_Sel};
  assign load  = !empty && (!io.res_valid || io.res_ready);
  alu_op_fifo #(.PROFUNDIDAD(PROFUNDIDAD)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_req (io.in_valid),
    .pop      (load),
    .wr_op    (wr_op),
    .head     (head),
    .ready    (io.in_ready),
    .empty    (empty),
    .count    (count)
  );
  // empty FIFO presents a NOP so the ALU settles to zero
  assign alu_A   = empty ? '0 : head.a;
  assign alu_B   = empty ? '0 : head.b;
  assign alu_Sel = empty ? ALU_NOP : head.sel;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      io.res_valid   <= 1'b0;
      io.res_Out     <= '0;
      io.res_coutfin <= 1'b0;
      io.res_z       <= 1'b0;
    end else if (load) begin
      io.res_valid   <= 1'b1;
      io.res_Out     <= alu_Out;
      io.res_coutfin <= alu_coutfin;
      io.res_z       <= alu_z;
    end else if (io.res_ready) begin
      io.res_valid   <= 1'b0;
    end
  end
endmodule
